// File: rtl/axi_wr2stream.sv
// AXI4 write-burst responder: accepts AW/W bursts, forwards in-window beats to a stream FIFO, answers one B per burst.
// Latency: a beat accepted at W on cycle N is visible on the stream at N+1 (first-word fall-through FIFO).
// Backpressure: WREADY drops while the FIFO is full (unless the burst is being dropped); TREADY low stalls the FIFO.
// Optional: define AXI_WR2STREAM_STAT_EN to add STAT_BURSTS/STAT_BEATS/STAT_ERRS saturating counters.
module axi_wr2stream #(
  parameter int                      AXI_WIDTH_ID = 4,
  parameter int                      AXI_WIDTH_AD = 32,
  parameter int                      AXI_WIDTH_DA = 32,
  parameter logic [AXI_WIDTH_AD-1:0] ADDR_BASE    = 'h0000_0000,
  parameter logic [AXI_WIDTH_AD-1:0] ADDR_SIZE    = 'h0000_1000,
  parameter int                      FIFO_DEPTH   = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [AXI_WIDTH_ID-1:0]   S_AWID,
  input  logic [AXI_WIDTH_AD-1:0]   S_AWADDR,
  input  logic [7:0]                S_AWLEN,
  input  logic [2:0]                S_AWSIZE,
  input  logic [1:0]                S_AWBURST,
  input  logic                      S_AWVALID,
  output logic                      S_AWREADY,
  input  logic [AXI_WIDTH_DA-1:0]   S_WDATA,
  input  logic [AXI_WIDTH_DA/8-1:0] S_WSTRB,
  input  logic                      S_WLAST,
  input  logic                      S_WVALID,
  output logic                      S_WREADY,
  output logic [AXI_WIDTH_ID-1:0]   S_BID,
  output logic [1:0]                S_BRESP,
  output logic                      S_BVALID,
  input  logic                      S_BREADY,
  output logic [AXI_WIDTH_DA-1:0]   M_TDATA,
  output logic [AXI_WIDTH_DA/8-1:0] M_TSTRB,
  output logic                      M_TLAST,
  output logic                      M_TVALID,
  input  logic                      M_TREADY
`ifdef AXI_WR2STREAM_STAT_EN
  ,
  output logic [31:0]               STAT_BURSTS,
  output logic [31:0]               STAT_BEATS,
  output logic [15:0]               STAT_ERRS
`endif
);

  localparam int STW      = AXI_WIDTH_DA / 8;
  localparam int EW       = AXI_WIDTH_DA + STW + 1;   // {data, strobe, last}
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int CW       = PW + 1;
  localparam int SUMW     = AXI_WIDTH_AD + 9;         // wide enough that base+burst bytes never wraps
  localparam int SIZE_LOG = $clog2(STW);
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SUMW-1:0] WIN_HI  = SUMW'(ADDR_BASE) + SUMW'(ADDR_SIZE);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e                  state_q, state_d;
  logic [AXI_WIDTH_ID-1:0] id_q, id_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    drop_q, drop_d;
  logic                    err_q, err_d;

  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wptr_q, rptr_q;
  logic [CW-1:0]           count_q;
  logic                    fifo_full, fifo_empty;
  logic                    push, pop;
  logic [EW-1:0]           push_dat, rd_dat;

  logic [SUMW-1:0]         aw_end;
  logic                    aw_drop, aw_err;
  logic                    w_last;
  logic                    unused_awburst;

  // Burst type is irrelevant here: beats are streamed in arrival order.
  assign unused_awburst = ^S_AWBURST;

  // Address window and beat-size checks evaluated on the AW request.
  always_comb begin
    aw_end  = SUMW'(S_AWADDR) + ((SUMW'(S_AWLEN) + SUMW'(1)) << S_AWSIZE);
    aw_drop = (S_AWADDR < ADDR_BASE) || (aw_end > WIN_HI);
    aw_err  = (S_AWSIZE != 3'(SIZE_LOG));
  end

  assign w_last     = (cnt_q == len_q);
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign push_dat   = {S_WDATA, S_WSTRB, w_last};

  // Burst FSM next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    err_d     = err_q;
    S_AWREADY = 1'b0;
    S_WREADY  = 1'b0;
    S_BVALID  = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        S_AWREADY = 1'b1;
        if (S_AWVALID) begin
          id_d    = S_AWID;
          len_d   = S_AWLEN;
          cnt_d   = '0;
          drop_d  = aw_drop;
          err_d   = aw_err;
          state_d = DATA;
        end
      end
      DATA: begin
        // Dropped bursts are sunk at full rate; kept bursts wait for FIFO room.
        S_WREADY = drop_q | ~fifo_full;
        if (S_WVALID && S_WREADY) begin
          push  = ~drop_q;
          cnt_d = cnt_q + 8'd1;
          if (S_WLAST != w_last) err_d = 1'b1;
          if (w_last) state_d = RESP;
        end
      end
      RESP: begin
        S_BVALID = 1'b1;
        if (S_BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign S_BID   = id_q;
  assign S_BRESP = drop_q ? 2'b11 : (err_q ? 2'b10 : 2'b00);

  // Burst FSM state and captured request fields.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign pop      = M_TVALID & M_TREADY;
  assign rd_dat   = mem_q[rptr_q];
  assign M_TVALID = ~fifo_empty;
  assign M_TDATA  = rd_dat[EW-1 -: AXI_WIDTH_DA];
  assign M_TSTRB  = rd_dat[STW:1];
  assign M_TLAST  = rd_dat[0] & ~fifo_empty;

  // FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge ACLK) begin
    if (push) mem_q[wptr_q] <= push_dat;
  end

`ifdef AXI_WR2STREAM_STAT_EN
  logic [31:0] bursts_q, beats_q;
  logic [15:0] errs_q;
  logic        b_hs;

  assign b_hs = S_BVALID & S_BREADY;

  // Saturating activity counters.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bursts_q <= '0;
      beats_q  <= '0;
      errs_q   <= '0;
    end else begin
      if (b_hs && !(&bursts_q))                       bursts_q <= bursts_q + 32'd1;
      if (push && !(&beats_q))                        beats_q  <= beats_q + 32'd1;
      if (b_hs && (S_BRESP != 2'b00) && !(&errs_q))   errs_q   <= errs_q + 16'd1;
    end
  end

  assign STAT_BURSTS = bursts_q;
  assign STAT_BEATS  = beats_q;
  assign STAT_ERRS   = errs_q;
`endif

endmodule

// File: tb/tb_axi_wr2stream.sv
// Randomised and directed bench for axi_wr2stream against a transaction-level model.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// A full FIFO stall and a mid-burst reset are exercised explicitly.
module tb_axi_wr2stream;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] WSIZE = 32'h0000_1000;

  logic        ACLK, ARESET;
  logic [3:0]  S_AWID;
  logic [31:0] S_AWADDR;
  logic [7:0]  S_AWLEN;
  logic [2:0]  S_AWSIZE;
  logic [1:0]  S_AWBURST;
  logic        S_AWVALID, S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WLAST, S_WVALID, S_WREADY;
  logic [3:0]  S_BID;
  logic [1:0]  S_BRESP;
  logic        S_BVALID, S_BREADY;
  logic [31:0] M_TDATA;
  logic [3:0]  M_TSTRB;
  logic        M_TLAST, M_TVALID, M_TREADY;

  axi_wr2stream #(
    .AXI_WIDTH_ID(4), .AXI_WIDTH_AD(32), .AXI_WIDTH_DA(32),
    .ADDR_BASE(BASE), .ADDR_SIZE(WSIZE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
    .S_AWBURST(S_AWBURST), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .M_TDATA(M_TDATA), .M_TSTRB(M_TSTRB), .M_TLAST(M_TLAST),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} beat_t;

  // Model: exp_q is exactly the set of beats that must be sitting in the DUT FIFO.
  beat_t      exp_q[$];
  beat_t      t_log[$];
  logic [5:0] b_log[$];
  int         m_phase = 0;   // 0 waiting for AW, 1 taking W, 2 responding
  bit         m_drop, m_err;
  int         m_len, m_beat;
  logic [3:0] m_id;
  int         w_acc = 0;
  int         tready_mode = 0; // 0 always ready, 1 stalled, 2 random

  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];

  // Single compare process: checks every output each cycle, then advances the model.
  always @(negedge ACLK) begin
    logic  exp_wr;
    logic [1:0] eb;
    if (ARESET) begin
      exp_q.delete();
      m_phase = 0;
      m_beat  = 0;
      chk("rst_awready", S_AWREADY, 1);
      chk("rst_wready",  S_WREADY,  0);
      chk("rst_bvalid",  S_BVALID,  0);
      chk("rst_bid",     S_BID,     0);
      chk("rst_bresp",   S_BRESP,   0);
      chk("rst_tvalid",  M_TVALID,  0);
      chk("rst_tlast",   M_TLAST,   0);
    end else begin
      exp_wr = (m_phase == 1) && (m_drop || exp_q.size() < DEPTH);
      eb     = m_drop ? 2'b11 : (m_err ? 2'b10 : 2'b00);
      chk("awready", S_AWREADY, m_phase == 0);
      chk("wready",  S_WREADY,  exp_wr);
      chk("bvalid",  S_BVALID,  m_phase == 2);
      chk("tvalid",  M_TVALID,  exp_q.size() != 0);
      if (m_phase == 2) begin
        chk("bid",   S_BID,   m_id);
        chk("bresp", S_BRESP, eb);
      end
      if (M_TVALID && exp_q.size() != 0) begin
        chk("tdata", M_TDATA, exp_q[0].d);
        chk("tstrb", M_TSTRB, exp_q[0].s);
        chk("tlast", M_TLAST, exp_q[0].l);
      end
      if (M_TVALID && M_TREADY) begin
        t_log.push_back({M_TDATA, M_TSTRB, M_TLAST});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      case (m_phase)
        0: if (S_AWVALID) begin
          m_id   = S_AWID;
          m_len  = int'(S_AWLEN);
          m_beat = 0;
          m_drop = (longint'(S_AWADDR) < longint'(BASE)) ||
                   (longint'(S_AWADDR) + (longint'(S_AWLEN) + 1) * (longint'(1) << S_AWSIZE)
                    > longint'(BASE) + longint'(WSIZE));
          m_err  = (S_AWSIZE != 3'd2);
          m_phase = 1;
        end
        1: if (S_WVALID && exp_wr) begin
          w_acc++;
          if (!m_drop) exp_q.push_back({S_WDATA, S_WSTRB, m_beat == m_len});
          if (S_WLAST != (m_beat == m_len)) m_err = 1'b1;
          if (m_beat == m_len) m_phase = 2;
          m_beat++;
        end
        2: if (S_BREADY) begin
          b_log.push_back({S_BID, S_BRESP});
          m_phase = 0;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Stream sink readiness.
  initial begin
    M_TREADY = 1'b1;
    forever begin
      @(posedge ACLK); #1;
      case (tready_mode)
        0:       M_TREADY = 1'b1;
        1:       M_TREADY = 1'b0;
        default: M_TREADY = 1'($urandom_range(1));
      endcase
    end
  end

  task automatic send_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input int last_at, input bit gaps);
    int t;
    @(posedge ACLK); #1;
    S_AWID = id; S_AWADDR = addr; S_AWLEN = 8'(len); S_AWSIZE = size;
    S_AWBURST = 2'b01; S_AWVALID = 1'b1;
    t = 0;
    do begin @(negedge ACLK); t++; end while (!S_AWREADY && t < 200);
    if (!S_AWREADY) begin chk("timeout_aw", 0, 1); S_AWVALID = 1'b0; return; end
    @(posedge ACLK); #1 S_AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        S_WVALID = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge ACLK);
        #1;
      end
      S_WDATA = wdat[i]; S_WSTRB = wstb[i]; S_WLAST = (i == last_at); S_WVALID = 1'b1;
      t = 0;
      do begin @(negedge ACLK); t++; end while (!S_WREADY && t < 500);
      if (!S_WREADY) begin chk("timeout_w", 0, 1); S_WVALID = 1'b0; return; end
      @(posedge ACLK); #1;
    end
    S_WVALID = 1'b0; S_WLAST = 1'b0;
    t = 0;
    do begin @(negedge ACLK); t++; end while (!S_BVALID && t < 200);
    if (!S_BVALID) begin chk("timeout_b", 0, 1); return; end
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge ACLK);
    @(posedge ACLK); #1 S_BREADY = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1 S_BREADY = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge ACLK); t++; end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(negedge ACLK);
  endtask

  int a0;

  initial begin
    S_AWID = '0; S_AWADDR = '0; S_AWLEN = '0; S_AWSIZE = '0; S_AWBURST = '0; S_AWVALID = 1'b0;
    S_WDATA = '0; S_WSTRB = '0; S_WLAST = 1'b0; S_WVALID = 1'b0; S_BREADY = 1'b0;
    ARESET = 1'b0;
    #1 ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    // Four-beat burst, always-ready sink.
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + 32'(i); wstb[i] = 4'hF; end
    t_log.delete();
    send_burst(4'd5, BASE + 32'h100, 3, 3'd2, 3, 1'b0);
    wait_drain();
    chk("t1_count", t_log.size(), 4);
    for (int i = 0; i < 4 && i < t_log.size(); i++) begin
      chk("t1_data", t_log[i].d, 32'hA0 + 32'(i));
      chk("t1_last", t_log[i].l, i == 3);
    end
    chk("t1_b", b_log[$], {4'd5, 2'b00});

    // Single beat with partial strobe.
    wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'b0101;
    t_log.delete();
    send_burst(4'd2, BASE, 0, 3'd2, 0, 1'b0);
    wait_drain();
    chk("t2_count", t_log.size(), 1);
    if (t_log.size() > 0) begin
      chk("t2_strb", t_log[0].s, 4'b0101);
      chk("t2_last", t_log[0].l, 1);
    end
    chk("t2_b", b_log[$], {4'd2, 2'b00});

    // Twenty beats into a stalled sink: only FIFO_DEPTH fit until the sink resumes.
    for (int i = 0; i < 20; i++) begin wdat[i] = 32'h300 + 32'(i); wstb[i] = 4'hF; end
    t_log.delete();
    tready_mode = 1;
    @(posedge ACLK); #1;
    a0 = w_acc;
    fork
      send_burst(4'd7, BASE, 19, 3'd2, 19, 1'b0);
      begin
        repeat (40) @(negedge ACLK);
        chk("t3_stall_beats", w_acc - a0, 16);
        chk("t3_wready_low", S_WREADY, 0);
        tready_mode = 0;
      end
    join
    wait_drain();
    chk("t3_count", t_log.size(), 20);
    for (int i = 0; i < 20 && i < t_log.size(); i++) chk("t3_order", t_log[i].d, 32'h300 + 32'(i));
    chk("t3_b", b_log[$], {4'd7, 2'b00});

    // Window boundaries: crossing the top, below the base, and an exact fit.
    t_log.delete();
    send_burst(4'd3, BASE + 32'hFFC, 1, 3'd2, 1, 1'b0);
    wait_drain();
    chk("t4_nostream", t_log.size(), 0);
    chk("t4_b", b_log[$], {4'd3, 2'b11});
    send_burst(4'd4, BASE - 32'h4, 0, 3'd2, 0, 1'b0);
    chk("t4_below_b", b_log[$], {4'd4, 2'b11});
    t_log.delete();
    send_burst(4'd6, BASE + 32'hFF8, 1, 3'd2, 1, 1'b0);
    wait_drain();
    chk("t4_fit_count", t_log.size(), 2);
    chk("t4_fit_b", b_log[$], {4'd6, 2'b00});

    // Beat size mismatch, then early WLAST, then a clean burst.
    send_burst(4'd8, BASE, 1, 3'd1, 1, 1'b0);
    chk("t5_size_b", b_log[$], {4'd8, 2'b10});
    t_log.delete();
    send_burst(4'd9, BASE, 3, 3'd2, 1, 1'b0);
    wait_drain();
    chk("t5_wlast_beats", t_log.size(), 4);
    chk("t5_wlast_b", b_log[$], {4'd9, 2'b10});
    send_burst(4'd10, BASE, 3, 3'd2, 3, 1'b0);
    chk("t5_next_b", b_log[$], {4'd10, 2'b00});
    wait_drain();

    // Reset after two of four beats with the sink stalled.
    tready_mode = 1;
    @(posedge ACLK); #1;
    S_AWID = 4'd1; S_AWADDR = BASE; S_AWLEN = 8'd3; S_AWSIZE = 3'd2; S_AWVALID = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1 S_AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      S_WDATA = 32'h55 + 32'(i); S_WSTRB = 4'hF; S_WLAST = 1'b0; S_WVALID = 1'b1;
      @(negedge ACLK);
      @(posedge ACLK); #1;
    end
    S_WVALID = 1'b0;
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("t6_awready", S_AWREADY, 1);
    chk("t6_bvalid",  S_BVALID,  0);
    chk("t6_tvalid",  M_TVALID,  0);
    tready_mode = 0;
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'h70 + 32'(i); wstb[i] = 4'hF; end
    t_log.delete();
    send_burst(4'd11, BASE + 32'h40, 3, 3'd2, 3, 1'b0);
    wait_drain();
    chk("t6_count", t_log.size(), 4);
    if (t_log.size() > 0) chk("t6_first", t_log[0].d, 32'h70);
    chk("t6_b", b_log[$], {4'd11, 2'b00});

    // Randomised bursts against the model.
    tready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      int len, last_at;
      logic [2:0] size;
      logic [31:0] addr;
      len  = int'($urandom_range(0, 24));
      size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      addr = (BASE - 32'h40 + 32'($urandom_range(0, 32'h1080))) & ~32'h3;
      last_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len + 1)) : len;
      for (int i = 0; i <= len; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
      send_burst(4'($urandom), addr, len, size, last_at, 1'b1);
    end
    tready_mode = 0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
